// File: rtl/adsr_env.sv
// rtl/adsr_env.sv - linear ADSR envelope generator driving the VCA control voltage
// Level moves one LSB per (rate+1) prescaler ticks; phase checks run before steps so level never wraps.
module adsr_env #(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [7:0] attack,
  input  logic [7:0] decay,
  input  logic [7:0] sustain,
  input  logic [7:0] release_rate,
  output logic [7:0] cv_out,
  output logic [2:0] state_out,
  output logic       active
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_level;
  logic [7:0]    w_level_nxt;
  logic [PW-1:0] r_pre_cnt;
  logic [7:0]    r_step_cnt;
  logic          r_gate_d;
  logic          w_tick;
  logic          w_rise;
  logic          w_timed;
  logic          w_step;
  logic [7:0]    w_rate;

  assign w_tick = (r_pre_cnt == PRE_LAST);
  assign w_rise = gate & ~r_gate_d;

  // Only the three sloped phases consume ticks; rates are read live every tick.
  always_comb begin
    w_rate  = 8'd0;
    w_timed = 1'b0;
    case (r_state)
      S_ATTACK: begin
        w_rate  = attack;
        w_timed = 1'b1;
      end
      S_DECAY: begin
        w_rate  = decay;
        w_timed = 1'b1;
      end
      S_RELEASE: begin
        w_rate  = release_rate;
        w_timed = 1'b1;
      end
      default: begin
        w_rate  = 8'd0;
        w_timed = 1'b0;
      end
    endcase
  end

  assign w_step = w_tick & w_timed & (r_step_cnt >= w_rate);

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    case (r_state)
      S_IDLE: begin
        w_level_nxt = 8'd0;
        if (w_rise) w_state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate)                 w_state_nxt = S_RELEASE;
        else if (r_level == 8'hFF) w_state_nxt = S_DECAY;
        else if (w_step)           w_level_nxt = r_level + 8'd1;
      end
      S_DECAY: begin
        if (!gate)                    w_state_nxt = S_RELEASE;
        else if (r_level <= sustain)  w_state_nxt = S_SUSTAIN;
        else if (w_step)              w_level_nxt = r_level - 8'd1;
      end
      S_SUSTAIN: begin
        if (!gate) w_state_nxt = S_RELEASE;
        else       w_level_nxt = sustain;
      end
      S_RELEASE: begin
        // Retrigger keeps the current level so the attack resumes without a click.
        if (w_rise)                w_state_nxt = S_ATTACK;
        else if (r_level == 8'd0)  w_state_nxt = S_IDLE;
        else if (w_step)           w_level_nxt = r_level - 8'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_level_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_level    <= 8'd0;
      r_pre_cnt  <= '0;
      r_step_cnt <= 8'd0;
      r_gate_d   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_gate_d  <= gate;
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_state_nxt != r_state)
        r_step_cnt <= 8'd0;
      else if (w_tick && w_timed)
        r_step_cnt <= w_step ? 8'd0 : r_step_cnt + 8'd1;
    end
  end

  assign cv_out    = r_level;
  assign state_out = r_state;
  assign active    = (r_state != S_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// tb/tb_adsr_env.sv - self-checking bench for adsr_env
// Table-driven phase sequence on a PRESCALE=1 instance, live-rate and random runs on a PRESCALE=4 instance.
module tb_adsr_env;

  localparam int P4 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       g1 = 1'b0, g4 = 1'b0;
  logic [7:0] a1 = 8'd0, d1 = 8'd0, s1 = 8'd128, rl1 = 8'd3;
  logic [7:0] a4 = 8'd0, d4 = 8'd0, s4 = 8'd0, rl4 = 8'd0;
  logic [7:0] cv1, cv4;
  logic [2:0] st1, st4;
  logic       act1, act4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adsr_env #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .gate(g1), .attack(a1), .decay(d1),
    .sustain(s1), .release_rate(rl1), .cv_out(cv1), .state_out(st1), .active(act1)
  );

  adsr_env #(.PRESCALE(P4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .gate(g4), .attack(a4), .decay(d4),
    .sustain(s4), .release_rate(rl4), .cv_out(cv4), .state_out(st4), .active(act4)
  );

  // Reference envelope for u_dut4: phase 0..4, level, ticks waited in the current phase.
  int m_ph = 0, m_lvl = 0, m_pre = 0, m_wait = 0;
  bit m_gd = 1'b0;

  always @(posedge clk) begin : ref_model
    int  rate, np, nl;
    bit  tick, rise, sloped, stp;
    if (!rst_n) begin
      m_ph <= 0; m_lvl <= 0; m_pre <= 0; m_wait <= 0; m_gd <= 1'b0;
    end else begin
      tick   = (m_pre == P4 - 1);
      rise   = g4 && !m_gd;
      rate   = (m_ph == 1) ? int'(a4) : (m_ph == 2) ? int'(d4) : int'(rl4);
      sloped = (m_ph == 1) || (m_ph == 2) || (m_ph == 4);
      stp    = tick && sloped && (m_wait >= rate);
      np = m_ph;
      nl = m_lvl;
      if (m_ph == 0) begin
        if (rise) np = 1;
      end else if (m_ph == 1) begin
        if (!g4) np = 4; else if (m_lvl == 255) np = 2; else if (stp) nl = m_lvl + 1;
      end else if (m_ph == 2) begin
        if (!g4) np = 4; else if (m_lvl <= int'(s4)) np = 3; else if (stp) nl = m_lvl - 1;
      end else if (m_ph == 3) begin
        if (!g4) np = 4; else nl = int'(s4);
      end else begin
        if (rise) np = 1; else if (m_lvl == 0) np = 0; else if (stp) nl = m_lvl - 1;
      end
      if (np != m_ph)    m_wait <= 0;
      else if (stp)      m_wait <= 0;
      else if (tick && sloped) m_wait <= m_wait + 1;
      m_ph  <= np;
      m_lvl <= nl;
      m_pre <= (m_pre + 1) % P4;
      m_gd  <= g4;
    end
  end

  typedef struct {
    logic       gate;
    logic [7:0] att, dec, sus, rel;
    int         n;
    logic [2:0] st;
    logic [7:0] cv;
    logic       act;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_cv"}, int'(cv4), m_lvl);
    check({tag, "_st"}, int'(st4), m_ph);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, n;
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd1, 8'd0,   1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   100, 3'd1, 8'd100, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   155, 3'd1, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd2, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd2, 8'd254, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   126, 3'd2, 8'd128, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd3, 8'd128, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd3,   20,  3'd3, 8'd128, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd4, 8'd128, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd3,   3,   3'd4, 8'd128, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd4, 8'd127, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd3,   508, 3'd4, 8'd0,   1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd3,   1,   3'd0, 8'd0,   1'b0});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd255, 1,   3'd1, 8'd0,   1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd255, 100, 3'd1, 8'd100, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd255, 1,   3'd4, 8'd100, 1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd128, 8'd255, 9,   3'd4, 8'd100, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd255, 1,   3'd1, 8'd100, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd128, 8'd255, 1,   3'd1, 8'd101, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 154, 3'd1, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 1,   3'd2, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 1,   3'd3, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd64,  8'd255, 1,   3'd3, 8'd64,  1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd64,  8'd0,   1,   3'd4, 8'd64,  1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd64,  8'd0,   64,  3'd4, 8'd0,   1'b1});
    vq.push_back('{1'b0, 8'd0, 8'd0, 8'd64,  8'd0,   1,   3'd0, 8'd0,   1'b0});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   1,   3'd1, 8'd0,   1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   255, 3'd1, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   1,   3'd2, 8'd255, 1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   255, 3'd2, 8'd0,   1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   1,   3'd3, 8'd0,   1'b1});
    vq.push_back('{1'b1, 8'd0, 8'd0, 8'd0,   8'd0,   5,   3'd3, 8'd0,   1'b1});

    // Reset with gate low: outputs zero during and after reset.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("rst_cv1", int'(cv1), 0);
      check("rst_st1", int'(st1), 0);
      check("rst_act1", int'(act1), 0);
      check("rst_cv4", int'(cv4), 0);
    end
    rst_n = 1'b1;
    repeat (3) clk1();
    check("post_rst_cv1", int'(cv1), 0);
    check("post_rst_st1", int'(st1), 0);
    check("post_rst_act1", int'(act1), 0);
    check_model("post_rst4");

    // Gate held high through reset enters ATTACK one clock after release.
    rst_n = 1'b0;
    g1 = 1'b1;
    repeat (3) clk1();
    check("gate_in_rst_st1", int'(st1), 0);
    rst_n = 1'b1;
    clk1();
    check("gate_rst_rise_st1", int'(st1), 1);
    check("gate_rst_rise_act1", int'(act1), 1);

    rst_n = 1'b0;
    g1 = 1'b0;
    repeat (2) clk1();
    rst_n = 1'b1;
    clk1();

    foreach (vq[i]) begin
      g1 = vq[i].gate; a1 = vq[i].att; d1 = vq[i].dec; s1 = vq[i].sus; rl1 = vq[i].rel;
      repeat (vq[i].n) clk1();
      check($sformatf("vec%0d_cv", i), int'(cv1), int'(vq[i].cv));
      check($sformatf("vec%0d_st", i), int'(st1), int'(vq[i].st));
      check($sformatf("vec%0d_act", i), int'(act1), int'(vq[i].act));
    end

    // Reset mid-envelope drops the level at once.
    rst_n = 1'b0; g1 = 1'b0; a1 = 8'd0;
    clk1();
    rst_n = 1'b1;
    clk1();
    g1 = 1'b1;
    repeat (51) clk1();
    check("mid_pre_cv1", int'(cv1), 50);
    rst_n = 1'b0;
    clk1();
    check("mid_rst_cv1", int'(cv1), 0);
    check("mid_rst_st1", int'(st1), 0);
    check("mid_rst_act1", int'(act1), 0);
    g1 = 1'b0;
    clk1();
    rst_n = 1'b1;

    // Live attack-rate change on the prescaled instance.
    g4 = 1'b1; a4 = 8'd200;
    for (int i = 0; i < 200; i++) begin
      clk1();
      if (i % 40 == 0) check_model("t6_wait");
    end
    check("t6_hold_cv", int'(cv4), 0);
    check("t6_hold_st", int'(st4), 1);
    a4 = 8'd10;
    k = 0;
    while (k < 8 && cv4 == 8'd0) begin
      clk1();
      k++;
    end
    check("t6_first_step_within_4", int'(k >= 1 && k <= 4), 1);
    check("t6_first_cv", int'(cv4), 1);
    for (int s = 2; s <= 3; s++) begin
      n = 0;
      while (n < 100 && int'(cv4) == s - 1) begin
        clk1();
        n++;
      end
      check($sformatf("t6_period%0d", s), n, 44);
      check($sformatf("t6_cv%0d", s), int'(cv4), s);
    end
    check_model("t6_end");

    // Random gate/rate/sustain traffic against the reference model.
    a4 = 8'd0; d4 = 8'd1; rl4 = 8'd0; s4 = 8'd100;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) g4 = ~g4;
      if ($urandom_range(0, 199) == 0) a4 = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) d4 = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) rl4 = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) s4 = 8'($urandom_range(0, 255));
      clk1();
      check_model("rand");
      check("rand_act", int'(act4), int'(m_ph != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
